// File: rtl/pwm_cfg_pkg.sv
// pwm_cfg_pkg: shared constants and types for the PWM configuration sequencer.
//   Register bank addresses, bank size, and the ramp engine state encoding.
package pwm_cfg_pkg;

  localparam logic [6:0] ADDR_OUT_LO  = 7'h00;
  localparam logic [6:0] ADDR_OUT_HI  = 7'h01;
  localparam logic [6:0] ADDR_PWM_LO  = 7'h02;
  localparam logic [6:0] ADDR_PWM_HI  = 7'h03;
  localparam logic [6:0] ADDR_DUTY    = 7'h04;
  localparam int unsigned NUM_CFG_REGS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } ramp_state_t;

endpackage

// File: rtl/pwm_cfg_sequencer_arb.sv
// rr_arb2: two-requester round-robin arbiter.
//   i_req[0] / i_req[1] : request lines (0 = SPI, 1 = ramp engine)
//   o_gnt[1:0]          : combinational one-hot grant
// The last-grant pointer only moves on a contested cycle; its reset value
// records requester 0 as the last winner, so the first contest goes to 1.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_last_was_1;

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = r_last_was_1 ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_was_1 <= 1'b0;
    end else if (i_req == 2'b11) begin
      r_last_was_1 <= o_gnt[1];
    end
  end

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// pwm_cfg_sequencer: PWM configuration register bank with a single write
// port shared between the SPI write channel and a duty-cycle ramp engine.
//   clk, rst                          : clock, synchronous active-high reset
//   spi_wr_valid/addr/data, _ready    : SPI write channel (valid/ready)
//   ramp_start/target/step/interval   : ramp command (start is a pulse)
//   ramp_busy, ramp_done, ramp_abort  : ramp status
//   en_reg_*, pwm_duty_cycle          : register bank 0x00..0x04
module pwm_cfg_sequencer
  import pwm_cfg_pkg::*;
#(
  parameter int unsigned INTERVAL_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_wr_valid,
  input  logic [6:0]            spi_wr_addr,
  input  logic [7:0]            spi_wr_data,
  output logic                  spi_wr_ready,
  input  logic                  ramp_start,
  input  logic [7:0]            ramp_target,
  input  logic [7:0]            ramp_step,
  input  logic [INTERVAL_W-1:0] ramp_interval,
  output logic                  ramp_busy,
  output logic                  ramp_done,
  output logic                  ramp_abort,
  output logic [7:0]            en_reg_out_7_0,
  output logic [7:0]            en_reg_out_15_8,
  output logic [7:0]            en_reg_pwm_7_0,
  output logic [7:0]            en_reg_pwm_15_8,
  output logic [7:0]            pwm_duty_cycle
);

  ramp_state_t           r_state;
  logic [INTERVAL_W-1:0] r_cnt;
  logic [INTERVAL_W-1:0] r_interval;
  logic [7:0]            r_target;
  logic [7:0]            r_step;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_abort;
  logic [7:0]            r_out_lo, r_out_hi, r_pwm_lo, r_pwm_hi, r_duty;

  logic                  w_spi_bank;
  logic                  w_spi_bypass;
  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  logic                  w_abort;
  logic [8:0]            w_sum;
  logic [8:0]            w_diff;
  logic [7:0]            w_next;

  // Requests are masked during reset so nothing is handshaken that will not land.
  assign w_spi_bank   = spi_wr_valid && (spi_wr_addr <= ADDR_DUTY) && !rst;
  assign w_spi_bypass = spi_wr_valid && (spi_wr_addr >  ADDR_DUTY) && !rst;
  assign w_req        = {(r_state == STEP) && !rst, w_spi_bank};
  assign spi_wr_ready = w_gnt[0] | w_spi_bypass;
  assign w_abort      = w_gnt[0] && (spi_wr_addr == ADDR_DUTY) &&
                        ((r_state == WAIT) || (r_state == STEP));

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  // Saturating step toward the target, evaluated against the live duty value.
  always_comb begin
    w_sum  = {1'b0, r_duty} + {1'b0, r_step};
    w_diff = {1'b0, r_duty} - {1'b0, r_step};
    w_next = r_target;
    if (r_target > r_duty) begin
      if (w_sum < {1'b0, r_target}) w_next = w_sum[7:0];
    end else if (r_target < r_duty) begin
      if (!w_diff[8] && (w_diff[7:0] > r_target)) w_next = w_diff[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_lo <= '0;
      r_out_hi <= '0;
      r_pwm_lo <= '0;
      r_pwm_hi <= '0;
      r_duty   <= '0;
    end else if (w_gnt[0]) begin
      case (spi_wr_addr)
        ADDR_OUT_LO: r_out_lo <= spi_wr_data;
        ADDR_OUT_HI: r_out_hi <= spi_wr_data;
        ADDR_PWM_LO: r_pwm_lo <= spi_wr_data;
        ADDR_PWM_HI: r_pwm_hi <= spi_wr_data;
        ADDR_DUTY:   r_duty   <= spi_wr_data;
        default:     ;
      endcase
    end else if (w_gnt[1]) begin
      r_duty <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_interval <= '0;
      r_target   <= '0;
      r_step     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      if (w_abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_abort <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (ramp_start) begin
              r_target   <= ramp_target;
              r_step     <= (ramp_step == '0) ? 8'd1 : ramp_step;
              r_interval <= (ramp_interval == '0) ? INTERVAL_W'(1) : ramp_interval;
              r_cnt      <= (ramp_interval == '0) ? INTERVAL_W'(1) : ramp_interval;
              r_busy     <= 1'b1;
              if (ramp_target == r_duty) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= WAIT;
              end
            end
          end
          WAIT: begin
            r_cnt <= r_cnt - INTERVAL_W'(1);
            if (r_cnt == INTERVAL_W'(1)) r_state <= STEP;
          end
          STEP: begin
            if (w_gnt[1]) begin
              if (w_next == r_target) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= WAIT;
                r_cnt   <= r_interval;
              end
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign ramp_busy       = r_busy;
  assign ramp_done       = r_done;
  assign ramp_abort      = r_abort;
  assign en_reg_out_7_0  = r_out_lo;
  assign en_reg_out_15_8 = r_out_hi;
  assign en_reg_pwm_7_0  = r_pwm_lo;
  assign en_reg_pwm_15_8 = r_pwm_hi;
  assign pwm_duty_cycle  = r_duty;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// tb_pwm_cfg_sequencer: directed bench for pwm_cfg_sequencer with
// hand-computed expected values. Cycle 0 is the cycle carrying ramp_start.
module tb_pwm_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_wr_valid;
  logic [6:0]  spi_wr_addr;
  logic [7:0]  spi_wr_data;
  logic        spi_wr_ready;
  logic        ramp_start;
  logic [7:0]  ramp_target;
  logic [7:0]  ramp_step;
  logic [15:0] ramp_interval;
  logic        ramp_busy, ramp_done, ramp_abort;
  logic [7:0]  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_chg, done_cnt, done_cyc, abort_cnt;
  int chg_val [0:7];
  int chg_cyc [0:7];

  pwm_cfg_sequencer #(.INTERVAL_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .spi_wr_valid    (spi_wr_valid),
    .spi_wr_addr     (spi_wr_addr),
    .spi_wr_data     (spi_wr_data),
    .spi_wr_ready    (spi_wr_ready),
    .ramp_start      (ramp_start),
    .ramp_target     (ramp_target),
    .ramp_step       (ramp_step),
    .ramp_interval   (ramp_interval),
    .ramp_busy       (ramp_busy),
    .ramp_done       (ramp_done),
    .ramp_abort      (ramp_abort),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d, input string tag);
    spi_wr_valid = 1'b1;
    spi_wr_addr  = a;
    spi_wr_data  = d;
    #1;
    check(tag, spi_wr_ready, 1);
    tick();
    spi_wr_valid = 1'b0;
  endtask

  task automatic start_ramp(input logic [7:0] t, input logic [7:0] s, input logic [15:0] iv);
    cyc           = 0;
    ramp_target   = t;
    ramp_step     = s;
    ramp_interval = iv;
    ramp_start    = 1'b1;
  endtask

  // Advance ncyc cycles, logging duty changes and status pulses.
  task automatic observe(input int ncyc);
    logic [7:0] prev;
    prev      = pwm_duty_cycle;
    n_chg     = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    abort_cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      ramp_start = 1'b0;
      if (pwm_duty_cycle != prev) begin
        if (n_chg < 8) begin
          chg_val[n_chg] = pwm_duty_cycle;
          chg_cyc[n_chg] = cyc;
        end
        n_chg++;
        prev = pwm_duty_cycle;
      end
      if (ramp_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (ramp_abort) abort_cnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; spi_wr_valid = 1'b0; spi_wr_addr = '0; spi_wr_data = '0;
    ramp_start = 1'b0; ramp_target = '0; ramp_step = '0; ramp_interval = '0;
    do_reset();

    // Reset state
    check("rst_out_lo", en_reg_out_7_0, 0);
    check("rst_duty", pwm_duty_cycle, 0);
    check("rst_busy", ramp_busy, 0);
    check("rst_done", ramp_done, 0);
    check("rst_abort", ramp_abort, 0);
    check("rst_ready", spi_wr_ready, 0);

    // Plain SPI writes, including one outside the bank
    spi_write(7'h00, 8'h0F, "rdy_00");
    spi_write(7'h01, 8'hA5, "rdy_01");
    spi_write(7'h04, 8'h33, "rdy_04");
    spi_write(7'h09, 8'h77, "rdy_09");
    check("reg_out_lo", en_reg_out_7_0, 8'h0F);
    check("reg_out_hi", en_reg_out_15_8, 8'hA5);
    check("reg_pwm_lo", en_reg_pwm_7_0, 8'h00);
    check("reg_pwm_hi", en_reg_pwm_15_8, 8'h00);
    check("reg_duty", pwm_duty_cycle, 8'h33);

    // Up-ramp 0x00 -> 0x0A, step 4, interval 3
    spi_write(7'h04, 8'h00, "rdy_d0");
    start_ramp(8'h0A, 8'd4, 16'd3);
    observe(18);
    check("up_nchg", n_chg, 3);
    check("up_v0", chg_val[0], 8'h04);
    check("up_c0", chg_cyc[0], 5);
    check("up_v1", chg_val[1], 8'h08);
    check("up_c1", chg_cyc[1], 9);
    check("up_v2", chg_val[2], 8'h0A);
    check("up_c2", chg_cyc[2], 13);
    check("up_done_n", done_cnt, 1);
    check("up_done_c", done_cyc, 13);
    check("up_busy_end", ramp_busy, 0);

    // Saturation at 0xFF
    spi_write(7'h04, 8'hFE, "rdy_dfe");
    start_ramp(8'hFF, 8'h80, 16'd1);
    observe(8);
    check("sat_nchg", n_chg, 1);
    check("sat_v0", chg_val[0], 8'hFF);
    check("sat_c0", chg_cyc[0], 3);
    check("sat_done_c", done_cyc, 3);

    // Down-ramp with floor at target
    spi_write(7'h04, 8'h05, "rdy_d05");
    start_ramp(8'h00, 8'd3, 16'd2);
    observe(10);
    check("dn_nchg", n_chg, 2);
    check("dn_v0", chg_val[0], 8'h02);
    check("dn_c0", chg_cyc[0], 4);
    check("dn_v1", chg_val[1], 8'h00);
    check("dn_c1", chg_cyc[1], 7);
    check("dn_done_c", done_cyc, 7);

    // Zero step and zero interval behave as 1
    spi_write(7'h04, 8'h10, "rdy_d10");
    start_ramp(8'h12, 8'd0, 16'd0);
    observe(8);
    check("z_nchg", n_chg, 2);
    check("z_v0", chg_val[0], 8'h11);
    check("z_c0", chg_cyc[0], 3);
    check("z_v1", chg_val[1], 8'h12);
    check("z_c1", chg_cyc[1], 5);

    // Target already reached: straight to DONE
    start_ramp(8'h12, 8'd1, 16'd4);
    observe(6);
    check("eq_nchg", n_chg, 0);
    check("eq_done_n", done_cnt, 1);
    check("eq_done_c", done_cyc, 1);

    // Contention, then abort
    do_reset();
    start_ramp(8'h10, 8'd1, 16'd2);
    tick(); ramp_start = 1'b0;                   // cycle 1
    check("ar_busy", ramp_busy, 1);
    tick();                                      // cycle 2
    tick();                                      // cycle 3: ramp STEP
    spi_wr_valid = 1'b1; spi_wr_addr = 7'h01; spi_wr_data = 8'h11;
    #1;
    check("ar1_spi_lose", spi_wr_ready, 0);
    tick();                                      // cycle 4
    check("ar1_duty", pwm_duty_cycle, 8'h01);
    check("ar1_hold", en_reg_out_15_8, 8'h00);
    check("ar1_spi_next", spi_wr_ready, 1);
    tick(); spi_wr_valid = 1'b0;                 // cycle 5
    check("ar1_reg", en_reg_out_15_8, 8'h11);
    tick();                                      // cycle 6: ramp STEP again
    spi_wr_valid = 1'b1; spi_wr_data = 8'h22;
    #1;
    check("ar2_spi_win", spi_wr_ready, 1);
    tick(); spi_wr_valid = 1'b0;                 // cycle 7
    check("ar2_reg", en_reg_out_15_8, 8'h22);
    check("ar2_duty_hold", pwm_duty_cycle, 8'h01);
    tick();                                      // cycle 8
    check("ar2_duty", pwm_duty_cycle, 8'h02);
    tick();                                      // cycle 9: WAIT
    spi_wr_valid = 1'b1; spi_wr_addr = 7'h04; spi_wr_data = 8'h40;
    #1;
    check("ab_ready", spi_wr_ready, 1);
    tick(); spi_wr_valid = 1'b0;                 // cycle 10
    check("ab_duty", pwm_duty_cycle, 8'h40);
    check("ab_pulse", ramp_abort, 1);
    check("ab_busy", ramp_busy, 0);
    observe(20);
    check("ab_nchg", n_chg, 0);
    check("ab_pulse_n", abort_cnt, 0);
    check("ab_done_n", done_cnt, 0);

    // ramp_start while busy is ignored
    spi_write(7'h04, 8'h00, "rdy_ign");
    start_ramp(8'h08, 8'd8, 16'd4);
    tick(); ramp_start = 1'b0;                   // cycle 1
    tick();                                      // cycle 2
    ramp_target = 8'h80; ramp_step = 8'h80; ramp_interval = 16'd1; ramp_start = 1'b1;
    observe(10);
    check("ign_nchg", n_chg, 1);
    check("ign_v0", chg_val[0], 8'h08);
    check("ign_c0", chg_cyc[0], 6);
    check("ign_done_n", done_cnt, 1);

    // Reset during WAIT, with an SPI request pending
    start_ramp(8'h20, 8'd1, 16'd5);
    tick(); ramp_start = 1'b0;
    tick();
    rst = 1'b1;
    spi_wr_valid = 1'b1; spi_wr_addr = 7'h00; spi_wr_data = 8'h55;
    #1;
    check("rw_ready", spi_wr_ready, 0);
    tick();
    rst = 1'b0; spi_wr_valid = 1'b0;
    check("rw_out_hi", en_reg_out_15_8, 0);
    check("rw_out_lo", en_reg_out_7_0, 0);
    check("rw_duty", pwm_duty_cycle, 0);
    check("rw_busy", ramp_busy, 0);
    observe(10);
    check("rw_nchg", n_chg, 0);
    check("rw_done_n", done_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
